sysin_pingpong_buf: RTL and testbench
=====================================

Name: sysin_pingpong_buf

Overview:
Parametrised, double-banked input buffer that feeds one operand stream (A or B) into the systolic array.
- The host writes one bank while the array streams a programmable-length run out of the other.
- The host read port has priority; a host read costs the array one stall cycle and never corrupts the stream.
- The run is sequenced by a small FSM with full-flag back-pressure and a done pulse.

Parameters:
DW, 16, data word width
AW, 9, address bits per bank (bank depth = 2^AW)
PAD, 4, zero words appended after each run (used only with SYSIN_ZPAD_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wen  in  1  host write enable
hst_wadr  in  AW+1  host write address; MSB = bank
hst_wdata  in  DW  host write data
ren  in  1  host read enable; has priority over the array stream
hst_radr  in  AW+1  host read address; MSB = bank
hst_rdata  out  DW  memory read data; valid 1 cycle after ren
start  in  1  one-cycle pulse that launches a run
bank_sel  in  1  bank streamed by the run; latched at start
len  in  AW+1  words in the run, 0..2^AW
ff  in  1  array input FIFO full; stalls issue
ab_in  out  DW  stream data to the array
we  out  1  ab_in valid strobe to the array
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values: we=0, busy=0, done=0, FSM=IDLE, address counter=0. ab_in and hst_rdata are memory output and undefined after reset. Memory contents are not reset.
- Memory is 2*2^AW x DW, one synchronous read port, one write port. Read latency is 1 cycle.
- Write and read to the same address in the same cycle: the read returns the old data.
- FSM states: IDLE, RUN, PADS (PADS exists only with the macro).
- IDLE -> RUN on start.
  - On that edge: latch bank_sel, latch len (values > 2^AW clamp to 2^AW), clear the counter, set busy=1 from the next cycle.
  - start with len=0: stay IDLE and pulse done the next cycle. busy stays 0.
- start while busy is ignored.
- Issue condition: state RUN & ~ff & ~ren.
  - In each issue cycle, read address {bank, cnt} and increment cnt.
  - we=1 exactly in the cycle after each issue, with ab_in = read data. Otherwise we=0.
- ren in the same cycle as a would-be issue: the host gets the port and the array issue is skipped that cycle. cnt holds, no word is lost or duplicated.
- The issue with cnt == len-1 is the last. The FSM returns to IDLE on that edge.
  - done=1 in the same cycle as the final we.
  - busy drops to 0 in the cycle after done.
- cnt width is AW+1 and does not wrap within a run. A run of 2^AW words reads every address in the bank exactly once.
- Host writes to the active bank during a run are not blocked. Words not yet issued return the new data.
- Asynchronous reset mid-run aborts immediately: IDLE, we=0, done=0, busy=0. No done pulse is produced.

Optional Feature:
Macro: SYSIN_ZPAD_EN.
- Defined: after the last data issue the FSM enters PADS instead of IDLE.
  - It emits PAD words with we=1 and ab_in forced to 0 (a registered zero-select overrides memory data).
  - Pad emission is stalled by ff but not by ren.
  - done coincides with the last pad word, then the FSM goes to IDLE.
  - len=0 with the macro: PAD zero words only, then done.
- Undefined: no PADS state, PAD unused, behaviour exactly as above.

Test Plan:
- Host writes bank 0 addr 0..7 = 0x1000+i; start, bank_sel=0, len=8, ff=0 -> we high for 8 consecutive cycles starting 2 cycles after start, ab_in=0x1000..0x1007, done on the 8th we, busy=0 the following cycle.
- Same run with ff=1 held 3 cycles mid-run -> exactly 8 we pulses, data in order, no gaps other than the 3 stall cycles.
- ren on hst_radr=0x205 during the run -> hst_rdata=bank-1 data the next cycle, one-cycle gap in we, stream still complete and ordered.
- Host fills bank 1 while bank 0 streams with len=512 -> all 512 words correct; then start bank 1 run with correct data.
- start with len=0 -> done pulse next cycle, we never high. start during busy -> ignored. rst_n low mid-run -> we/busy/done 0 immediately.
- With SYSIN_ZPAD_EN, PAD=4, len=3 -> 3 data words then 4 words of 0x0000, done on the 7th we.

Source files
------------

// File: rtl/sysin_pingpong_buf_if.sv
// Host, run-control and stream signals of the double-banked systolic input buffer.
// master = host/array side, slave = buffer side.
interface sysin_pingpong_buf_if #(
    parameter int DW = 16,
    parameter int AW = 9
);
    logic          wen;
    logic [AW:0]   hst_wadr;
    logic [DW-1:0] hst_wdata;
    logic          ren;
    logic [AW:0]   hst_radr;
    logic [DW-1:0] hst_rdata;
    logic          start;
    logic          bank_sel;
    logic [AW:0]   len;
    logic          ff;
    logic [DW-1:0] ab_in;
    logic          we;
    logic          busy;
    logic          done;

    modport master (
        output wen, hst_wadr, hst_wdata,
        output ren, hst_radr,
        output start, bank_sel, len, ff,
        input  hst_rdata, ab_in, we, busy, done
    );

    modport slave (
        input  wen, hst_wadr, hst_wdata,
        input  ren, hst_radr,
        input  start, bank_sel, len, ff,
        output hst_rdata, ab_in, we, busy, done
    );
endinterface

// File: rtl/sysin_pingpong_buf.sv
// Ping-pong operand buffer: host fills one bank while a run streams the other.
// Optional SYSIN_ZPAD_EN appends PAD zero words after each run.
module sysin_pingpong_buf #(
    parameter int DW  = 16,
    parameter int AW  = 9,
    parameter int PAD = 4
) (
    input  logic clk,
    input  logic rst_n,
    sysin_pingpong_buf_if.slave bus
);
    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] LMAX  = (AW+1)'(DEPTH);

`ifdef SYSIN_ZPAD_EN
    localparam int PW = (PAD > 1) ? $clog2(PAD + 1) : 1;
    typedef enum logic [1:0] {IDLE, RUN, PADS} state_e;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_e;
`endif

    state_e        state_q, state_d;
    logic          bank_q, bank_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          issue;
    logic [AW:0]   len_c;
    logic [AW:0]   rd_adr;
    logic          rd_en;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] mem [2*DEPTH];

`ifdef SYSIN_ZPAD_EN
    logic [PW-1:0] pad_q, pad_d;
    logic          zsel_q, zsel_d;
`else
    logic          unused_pad;
    assign unused_pad = (PAD != 0);
`endif

    assign len_c = (bus.len > LMAX) ? LMAX : bus.len;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        issue   = 1'b0;
`ifdef SYSIN_ZPAD_EN
        pad_d   = pad_q;
        zsel_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start && !busy_q) begin
                    bank_d = bus.bank_sel;
                    len_d  = len_c;
                    cnt_d  = '0;
                    if (len_c != '0) begin
                        state_d = RUN;
                    end else begin
`ifdef SYSIN_ZPAD_EN
                        if (PAD > 0) begin
                            state_d = PADS;
                            pad_d   = '0;
                        end else begin
                            done_d = 1'b1;
                        end
`else
                        done_d = 1'b1;
`endif
                    end
                end
            end
            RUN: begin
                // host read owns the single read port this cycle
                if (!bus.ff && !bus.ren) begin
                    issue = 1'b1;
                    we_d  = 1'b1;
                    cnt_d = cnt_q + (AW+1)'(1);
                    if (cnt_q == len_q - (AW+1)'(1)) begin
`ifdef SYSIN_ZPAD_EN
                        if (PAD > 0) begin
                            state_d = PADS;
                            pad_d   = '0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef SYSIN_ZPAD_EN
            PADS: begin
                if (!bus.ff) begin
                    we_d   = 1'b1;
                    zsel_d = 1'b1;
                    pad_d  = pad_q + PW'(1);
                    if (pad_q == PW'(PAD - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // busy covers the done cycle of a real run, not a zero-length one
        busy_d = (state_d != IDLE) || (done_d && (state_q != IDLE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SYSIN_ZPAD_EN
            pad_q   <= '0;
            zsel_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SYSIN_ZPAD_EN
            pad_q   <= pad_d;
            zsel_q  <= zsel_d;
`endif
        end
    end

    assign rd_adr = bus.ren ? bus.hst_radr : {bank_q, cnt_q[AW-1:0]};
    assign rd_en  = bus.ren | issue;

    always_ff @(posedge clk) begin
        if (bus.wen) mem[bus.hst_wadr] <= bus.hst_wdata;
        if (rd_en) rd_q <= mem[rd_adr];
    end

    assign bus.hst_rdata = rd_q;
`ifdef SYSIN_ZPAD_EN
    assign bus.ab_in = zsel_q ? '0 : rd_q;
`else
    assign bus.ab_in = rd_q;
`endif
    assign bus.we   = we_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_sysin_pingpong_buf.sv
// Directed bench for sysin_pingpong_buf: streams, stalls, host reads, resets.
// Pad expectations follow SYSIN_ZPAD_EN.
module tb_sysin_pingpong_buf;
    localparam int DW = 16;
    localparam int AW = 9;
`ifdef SYSIN_ZPAD_EN
    localparam int NP = 4;
`else
    localparam int NP = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    logic [DW-1:0] model [1024];

    sysin_pingpong_buf_if #(.DW(DW), .AW(AW)) bus ();

    sysin_pingpong_buf #(.DW(DW), .AW(AW), .PAD(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        bus.wen       = 1'b1;
        bus.hst_wadr  = a;
        bus.hst_wdata = d;
        model[a]      = d;
        @(negedge clk);
        bus.wen = 1'b0;
    endtask

    // Starts a run at the current negedge and follows it to busy=0.
    task automatic run(input string tag, input logic bk,
                       input logic [9:0] ln, input int n_exp,
                       input int exp_done, input int ff_s, input int ff_n,
                       input int ren_c, input logic [9:0] ren_a,
                       input int rst_c, input int w_c, input int w_n,
                       input logic [9:0] w_base, input logic [15:0] w_seed);
        int k;
        int done_c;
        int first_c;
        int nd;
        logic [9:0] idx;
        logic [9:0] wa;
        logic [15:0] ev;
        k       = 0;
        done_c  = 0;
        first_c = 0;
        nd      = (ln > 10'd512) ? 512 : int'(ln);
        bus.start    = 1'b1;
        bus.bank_sel = bk;
        bus.len      = ln;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (ren_c >= 0 && c == ren_c + 1)
                chk({tag, "_hrd"}, 32'(bus.hst_rdata), 32'(model[ren_a]));
            if (c == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
            if (bus.we === 1'b1) begin
                if (first_c == 0) first_c = c;
                idx = {bk, 9'(k)};
                ev  = (k < nd) ? model[idx] : 16'h0000;
                chk({tag, "_data"}, 32'(bus.ab_in), 32'(ev));
                k++;
                chk({tag, "_done"}, 32'(bus.done), 32'(k == n_exp));
            end else if (bus.done !== 1'b0) begin
                chk({tag, "_done_we"}, 32'(bus.we), 32'd1);
            end
            if (bus.done === 1'b1) begin
                done_c = c;
                chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
            end
            if (done_c > 0 && c == done_c + 1) begin
                chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
                break;
            end
            bus.start = (c == rst_c);
            if (c == rst_c) begin
                bus.bank_sel = ~bk;
                bus.len      = 10'd2;
            end
            bus.ff       = (c >= ff_s) && (c < ff_s + ff_n);
            bus.ren      = (c == ren_c);
            bus.hst_radr = ren_a;
            if (c >= w_c && c < w_c + w_n) begin
                wa            = w_base + 10'(c - w_c);
                bus.wen       = 1'b1;
                bus.hst_wadr  = wa;
                bus.hst_wdata = w_seed + 16'(c - w_c);
                model[wa]     = bus.hst_wdata;
            end else begin
                bus.wen = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.ff    = 1'b0;
        bus.ren   = 1'b0;
        bus.wen   = 1'b0;
        chk({tag, "_nwe"}, 32'(k), 32'(n_exp));
        chk({tag, "_done_cyc"}, 32'(done_c), 32'(exp_done));
        if (ff_s > 2 && ren_c < 0 && n_exp > 0)
            chk({tag, "_first"}, 32'(first_c), 32'd2);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.wen = 1'b0; bus.hst_wadr = '0; bus.hst_wdata = '0;
        bus.ren = 1'b0; bus.hst_radr = '0;
        bus.start = 1'b0; bus.bank_sel = 1'b0; bus.len = '0; bus.ff = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) wr(10'(i), 16'h1000 + 16'(i));
        run("r8", 1'b0, 10'd8, 8 + NP, 9 + NP, 100, 0, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);
        run("ff", 1'b0, 10'd8, 8 + NP, 12 + NP, 4, 3, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);
        wr(10'h205, 16'hBEEF);
        run("ren", 1'b0, 10'd8, 8 + NP, 10 + NP, 100, 0, 3, 10'h205,
            -1, 0, 0, 10'd0, 16'h0);
        run("sib", 1'b0, 10'd4, 4 + NP, 5 + NP, 100, 0, -1, 10'd0,
            3, 0, 0, 10'd0, 16'h0);
        run("aw", 1'b0, 10'd8, 8 + NP, 9 + NP, 100, 0, -1, 10'd0,
            -1, 2, 1, 10'd7, 16'h7777);

`ifdef SYSIN_ZPAD_EN
        run("len0", 1'b0, 10'd0, NP, 1 + NP, 100, 0, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);
`else
        bus.start = 1'b1;
        bus.len   = 10'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("len0_done", 32'(bus.done), 32'd1);
        chk("len0_we", 32'(bus.we), 32'd0);
        chk("len0_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("len0_done2", 32'(bus.done), 32'd0);
        chk("len0_we2", 32'(bus.we), 32'd0);
`endif

        for (int i = 0; i < 512; i++) wr(10'(i), 16'h1000 + 16'(i));
        run("full", 1'b0, 10'd512, 512 + NP, 513 + NP, 2000, 0, -1, 10'd0,
            -1, 1, 512, 10'h200, 16'hA000);
        run("b1", 1'b1, 10'd512, 512 + NP, 513 + NP, 2000, 0, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);
        run("clamp", 1'b1, 10'd700, 512 + NP, 513 + NP, 2000, 0, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);
        run("l3", 1'b1, 10'd3, 3 + NP, 4 + NP, 100, 0, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);

        bus.start    = 1'b1;
        bus.bank_sel = 1'b0;
        bus.len      = 10'd8;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we", 32'(bus.we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.we), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_we", 32'(bus.we), 32'd0);
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_done", 32'(bus.done), 32'd0);
        run("post", 1'b0, 10'd8, 8 + NP, 9 + NP, 100, 0, -1, 10'd0,
            -1, 0, 0, 10'd0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
